mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 select datapath (a 16-way operand/bus mux) among 16 requesters.
- Grants one requester at a time, drives the 4-bit mux select and a one-hot grant, and holds the grant until the owner signals done.
- Sits in the CPU datapath between the requesting units and the shared mux select input.

Parameters:
N_REQ, 16, number of requesters (fixed at 16 in this revision)
SEL_W, 4, select width, equals log2(N_REQ)
MAX_HOLD, 64, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  16  request vector; bit i is requester i
done  input  1  current owner releases the grant; sampled only while a grant is held
grant_valid  output  1  a grant is currently held
grant_sel  output  4  index of the granted requester; drives the mux select
grant_onehot  output  16  one-hot form of grant_sel; all zero when grant_valid=0
timeout  output  1  one-cycle pulse when a grant is force-released (ARB_TIMEOUT_EN only)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant_valid=0, grant_sel=0, grant_onehot=0, timeout=0, priority pointer ptr=0, hold counter=0.
- All outputs are registered. grant_onehot == (grant_valid ? 1<<grant_sel : 0) at all times.
- Pick rule: the winner is the first set bit of req scanning circularly from index ptr upward, wrapping 15->0.
- IDLE:
  - If req != 0 at an edge, go to BUSY and register the winner on grant_sel with grant_valid=1.
  - Latency is 1 cycle from req seen to grant visible.
  - done is ignored in IDLE.
- BUSY:
  - Grant is held unchanged until done=1. req changes are ignored, including the owner dropping its req.
  - On an edge with done=1, set ptr = (grant_sel+1) mod 16.
  - In that same edge, re-arbitrate using the new ptr with the current req:
    - If a winner exists, stay BUSY with the new grant, with no bubble cycle.
    - Otherwise go to IDLE with grant_valid=0 and grant_sel holding its last value.
  - The previous owner wins the re-arbitration only if it is the sole requester.
- ptr advances only on release, never on grant.
- Wrap: owner 15 releases -> ptr=0.
- Reset asserted mid-grant clears the grant immediately (async). The first grant after reset starts the scan from index 0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every new grant and increments each BUSY cycle without done.
  - When the counter reaches MAX_HOLD-1 and done=0, the arbiter releases exactly as if done=1 (ptr advance and re-arbitration in the same edge) and pulses timeout=1 for one cycle.
  - done and timeout in the same edge count as a normal release, with timeout=0.
- Undefined: no counter exists, timeout is tied to 0, and a grant may be held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - constants N_REQ=16 and SEL_W=4
  - typedef arb_state_t enum {IDLE, BUSY}
  - typedef sel_t logic [SEL_W-1:0]
- One combinational sub-module, rr_pick16, with inputs req[15:0] and ptr[3:0] and outputs found and idx[3:0] implementing the circular first-set scan. The arbiter instantiates it once.

Test Plan:
- Reset with req=16'h0000 -> grant_valid=0, grant_sel=0, grant_onehot=0. Then req=16'h0020 -> next edge grant_sel=5, grant_onehot=16'h0020.
- Fairness: req=16'h8001 held, done pulsed every 2nd cycle -> grants alternate 0,15,0,15 with no idle cycle between them.
- Wrap: owner 15 releases with req=16'hC002 -> next grant=1 (ptr wrapped to 0); a later release of owner 1 -> grant=14.
- Hold: owner 3 drops req without done, other reqs high for 10 cycles -> grant_sel stays 3 throughout. done=1 in IDLE -> no state change.
- Async reset mid-grant: reset_n low between edges while grant_sel=9 -> outputs zero immediately. After release, req=16'h0300 -> grant=8.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: owner 2 never asserts done, req=16'h0014 -> release after 4 BUSY cycles, timeout=1 for one cycle, new grant=4.

Source files
------------

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the round-robin mux select arbiter.
// Package arb_pkg: N_REQ, SEL_W, arb_state_t, sel_t, onehot helper.
package arb_pkg;

   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   typedef logic [SEL_W-1:0] sel_t;

   function automatic logic [N_REQ-1:0] onehot(sel_t s);
      logic [N_REQ-1:0] r;
      r    = '0;
      r[s] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between requesting units and the arbiter.
// master: requester side (req, done); slave: arbiter side (grants).
interface mux_sel_arbiter_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic             grant_valid;
   sel_t             grant_sel;
   logic [N_REQ-1:0] grant_onehot;
   logic             timeout;

   modport master (
      output req,
      output done,
      input  grant_valid,
      input  grant_sel,
      input  grant_onehot,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output grant_valid,
      output grant_sel,
      output grant_onehot,
      output timeout
   );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick16.sv
// Circular first-set scan of a 16-bit request vector from index ptr.
// Ports: req[15:0], ptr[3:0] in; found, idx[3:0] out. Combinational.
module rr_pick16
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  sel_t             ptr,
   output logic             found,
   output sel_t             idx
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   sel_t               off;

   // Rotate so that bit ptr lands at position 0; the lowest set bit
   // of the rotated vector is then the circular distance from ptr.
   assign dbl = {req, req} >> ptr;
   assign rot = dbl[N_REQ-1:0];

   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = sel_t'(i);
         end
      end
   end

   assign idx = ptr + off;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter granting a shared 16:1 mux select to 16 units.
// Ports: clk, reset_n (async low), bus (slave modport of
// mux_sel_arbiter_if). Optional ARB_TIMEOUT_EN adds MAX_HOLD and a
// forced release with a one-cycle timeout pulse.
module mux_sel_arbiter
   import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
   parameter int MAX_HOLD = 64
)
`endif
(
   input  logic               clk,
   input  logic               reset_n,
   mux_sel_arbiter_if.slave   bus
);

   arb_state_t       state_q, state_d;
   sel_t             ptr_q, ptr_d;
   sel_t             sel_q, sel_d;
   logic             valid_q, valid_d;
   logic [N_REQ-1:0] oh_q, oh_d;
   logic             tmo_q, tmo_d;

   sel_t             pick_ptr;
   logic             found;
   sel_t             idx;
   logic             rel;
   logic             tmo_hit;

   // On release the scan starts just past the owner, which is also
   // the new pointer value, so re-arbitration needs no extra cycle.
   assign pick_ptr = (state_q == BUSY) ? sel_q + sel_t'(1) : ptr_q;

   rr_pick16 u_pick (
      .req   (bus.req),
      .ptr   (pick_ptr),
      .found (found),
      .idx   (idx)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD) + 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tmo_hit = (state_q == BUSY) && !bus.done
                 && (cnt_q == CW'(MAX_HOLD - 1));

   // Counts BUSY cycles of the current owner; zero whenever a new
   // grant is taken or the arbiter is idle.
   always_comb begin
      cnt_d = '0;
      if (state_q == BUSY && !rel)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   assign rel = (state_q == BUSY) && (bus.done || tmo_hit);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BUSY;
               sel_d   = idx;
               valid_d = 1'b1;
            end
         end
         BUSY: begin
            if (rel) begin
               ptr_d = sel_q + sel_t'(1);
               tmo_d = !bus.done;
               if (found) begin
                  sel_d = idx;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      oh_d = valid_d ? onehot(sel_d) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         oh_q    <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         oh_q    <= oh_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.grant_valid  = valid_q;
   assign bus.grant_sel    = sel_q;
   assign bus.grant_onehot = oh_q;
   assign bus.timeout      = tmo_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: vector table, corner
// sequences, and random traffic against a round-robin reference.
module tb_mux_sel_arbiter;

   localparam int MH = 4;

   logic clk;
   logic reset_n;

   mux_sel_arbiter_if bus ();

`ifdef ARB_TIMEOUT_EN
   mux_sel_arbiter #(.MAX_HOLD(MH)) dut (
`else
   mux_sel_arbiter dut (
`endif
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference state: who holds the grant, where the next scan
   // starts, how long the owner has held it.
   bit      m_valid;
   int      m_sel;
   int      m_ptr;
   int      m_hold;
   bit      m_tmo;

   function automatic int pick(logic [15:0] r, int p);
      for (int k = 0; k < 16; k++)
         if (r[(p + k) % 16]) return (p + k) % 16;
      return -1;
   endfunction

   task automatic mdl_reset();
      m_valid = 0; m_sel = 0; m_ptr = 0;
      m_hold = 0; m_tmo = 0;
   endtask

   task automatic mdl_edge(logic [15:0] r, logic d);
      bit expire;
      m_tmo = 0;
      if (!m_valid) begin
         if (r != 0) begin
            m_valid = 1; m_sel = pick(r, m_ptr); m_hold = 0;
         end
      end else begin
         expire = 0;
`ifdef ARB_TIMEOUT_EN
         expire = (m_hold == MH - 1);
`endif
         if (d || expire) begin
            m_tmo = !d;
            m_ptr = (m_sel + 1) % 16;
            m_hold = 0;
            if (r != 0) m_sel = pick(r, m_ptr);
            else m_valid = 0;
         end else begin
            m_hold++;
         end
      end
   endtask

   task automatic check(string nm, bit ev, int es,
                        logic [15:0] eoh, bit et);
      n_vec++;
      if (bus.grant_valid !== ev ||
          bus.grant_sel !== 4'(es) ||
          bus.grant_onehot !== eoh ||
          bus.timeout !== et) begin
         n_bad++;
         $display("FAIL %s: got v=%0b s=%0d oh=%h t=%0b want v=%0b s=%0d oh=%h t=%0b",
                  nm, bus.grant_valid, bus.grant_sel,
                  bus.grant_onehot, bus.timeout, ev, es, eoh, et);
      end
   endtask

   function automatic logic [15:0] moh();
      logic [15:0] r;
      r = '0;
      if (m_valid) r[m_sel] = 1'b1;
      return r;
   endfunction

   task automatic check_mdl(string nm);
      check(nm, m_valid, m_sel, moh(), m_tmo);
   endtask

   // Inputs change #1 after an edge; outputs sampled #1 after the
   // next edge, once the model has seen the same inputs.
   task automatic drive(logic [15:0] r, logic d);
      bus.req  = r;
      bus.done = d;
   endtask

   task automatic step();
      @(posedge clk);
      mdl_edge(bus.req, bus.done);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      drive(16'h0, 1'b0);
      mdl_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      mdl_edge(bus.req, bus.done);
      #1;
   endtask

   typedef struct {
      logic [15:0] req;
      logic        done;
      bit          v;
      int          s;
      logic [15:0] oh;
   } vec_t;

   vec_t tbl[$];

   initial begin
      reset_n = 1'b1;
      drive(16'h0, 1'b0);
      mdl_reset();

      tbl = '{
         '{16'h0000, 1'b0, 0,  0, 16'h0000},
         '{16'h0020, 1'b0, 1,  5, 16'h0020},
         '{16'h0000, 1'b1, 0,  5, 16'h0000},
         '{16'h0000, 1'b1, 0,  5, 16'h0000},
         '{16'h8001, 1'b0, 1, 15, 16'h8000},
         '{16'h8001, 1'b1, 1,  0, 16'h0001},
         '{16'h8001, 1'b0, 1,  0, 16'h0001},
         '{16'h8001, 1'b1, 1, 15, 16'h8000},
         '{16'h8001, 1'b0, 1, 15, 16'h8000},
         '{16'hC002, 1'b1, 1,  1, 16'h0002},
         '{16'hC002, 1'b0, 1,  1, 16'h0002},
         '{16'hC002, 1'b1, 1, 14, 16'h4000},
         '{16'h0000, 1'b1, 0, 14, 16'h0000},
         '{16'h0008, 1'b0, 1,  3, 16'h0008}
      };

      do_reset();
      check("reset", 0, 0, 16'h0, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].req, tbl[i].done);
         step();
         check($sformatf("tbl%0d", i), tbl[i].v, tbl[i].s,
               tbl[i].oh, 1'b0);
      end

      // Owner 3 drops its request, others keep asking: no change.
      drive(16'h00F0, 1'b0);
      for (int c = 0; c < 10; c++) begin
`ifdef ARB_TIMEOUT_EN
         if (c == MH - 1) break;
`endif
         step();
         check($sformatf("hold%0d", c), 1, 3, 16'h0008, 0);
      end
      drive(16'h00F0, 1'b1);
      step();
      check_mdl("hold_rel");
      check("hold_rel4", 1, 4, 16'h0010, 0);

      // Release owner 4 onto 9, then reset between edges.
      drive(16'h0200, 1'b1);
      step();
      check("pre_rst9", 1, 9, 16'h0200, 0);
      drive(16'h0200, 1'b0);
      #2;
      reset_n = 1'b0;
      mdl_reset();
      #1;
      check("async_rst", 0, 0, 16'h0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(16'h0300, 1'b0);
      step();
      check("post_rst8", 1, 8, 16'h0100, 0);

      // done while idle must be ignored.
      drive(16'h0000, 1'b1);
      step();
      check("to_idle", 0, 8, 16'h0, 0);
      drive(16'h0000, 1'b1);
      step();
      check("idle_done", 0, 8, 16'h0, 0);

`ifdef ARB_TIMEOUT_EN
      do_reset();
      drive(16'h0004, 1'b0);
      step();
      check("tmo_g2", 1, 2, 16'h0004, 0);
      drive(16'h0014, 1'b0);
      for (int c = 1; c < MH; c++) begin
         step();
         check($sformatf("tmo_wait%0d", c), 1, 2, 16'h0004, 0);
      end
      step();
      check("tmo_fire", 1, 4, 16'h0010, 1);
      step();
      check("tmo_pulse", 1, 4, 16'h0010, 0);
`endif

      // Random traffic against the reference.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic [15:0] r;
         r = 16'($urandom);
         if ($urandom_range(3) == 0) r = r & 16'($urandom);
         if ($urandom_range(7) == 0) r = '0;
         drive(r, ($urandom_range(2) == 0));
         step();
         check_mdl($sformatf("rnd%0d", c));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
